// File: rtl/sram22_512x64_req_ctrl.sv
// sram22_512x64_req_ctrl
// Valid/ready request front-end for the 512x64 byte-masked single-port SRAM
// macro. Drives the macro port combinationally from the accepted request.
// Captures read data one cycle after issue and returns it in order through a
// small response FIFO. A credit check keeps requests from overrunning the FIFO.
module sram22_512x64_req_ctrl #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 64,
    parameter int WMASK_WIDTH = DATA_WIDTH / 8,
    parameter int RSP_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rstb,
    // request channel
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    // response channel
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_WIDTH-1:0]  rsp_rdata,
    // macro port
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RSP_DEPTH - 1);

    // Circular pointer advance; wraps explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    logic                  fire;
    logic                  pop;
    logic                  push;
    logic                  rd_pend;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W:0]        credit;
    logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];

    // Handshakes. A read is in flight for exactly one cycle (rd_pend); its
    // data lands in the FIFO at the following edge, so rd_pend is the push.
    assign pop  = rsp_valid & rsp_ready;
    assign push = rd_pend;
    assign fire = req_valid & req_ready;

    // Credit check: occupied entries plus the in-flight read, minus the entry
    // leaving this cycle. This makes req_ready combinational from rsp_ready,
    // which is what allows one request per cycle under a free-flowing sink.
    // Holding it low during reset keeps the macro from seeing a write then.
    assign credit    = {1'b0, count} + {{CNT_W{1'b0}}, rd_pend} - {{CNT_W{1'b0}}, pop};
    assign req_ready = rstb & (credit < DEPTH_EXT);

    // Macro drive. Address and data follow the request bus unconditionally;
    // idle cycles therefore issue harmless reads whose data is never sampled.
    assign sram_addr  = req_addr;
    assign sram_din   = req_wdata;
    assign sram_we    = fire & req_we;
    assign sram_wmask = (fire & req_we) ? req_wmask : '0;

    // Response head. Entries are only written at push, so the head is stable
    // while the client stalls.
    assign rsp_valid = (count != '0);
    assign rsp_rdata = rsp_mem[rd_ptr];

    // Read-pending flag: one cycle high after each accepted read.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= fire & ~req_we;
        end
    end

    // FIFO pointers and occupancy. Simultaneous push and pop leave the count
    // unchanged while both pointers advance.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage. The macro output is sampled only on the cycle after a read
    // issue; at any other time it is X (after writes) or idle-read noise.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                rsp_mem[i] <= '0;
            end
        end else if (push) begin
            rsp_mem[wr_ptr] <= sram_dout;
        end
    end

endmodule

// File: tb/tb_sram22_512x64_req_ctrl.sv
// Directed bench for sram22_512x64_req_ctrl with a behavioural byte-masked
// synchronous SRAM model attached to the macro port.
module tb_sram22_512x64_req_ctrl;

    logic        clk = 1'b0;
    logic        rstb;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_wmask;
    logic [8:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        sram_we;
    logic [7:0]  sram_wmask;
    logic [8:0]  sram_addr;
    logic [63:0] sram_din;
    logic [63:0] sram_dout;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem [512];

    sram22_512x64_req_ctrl dut (
        .clk        (clk),
        .rstb       (rstb),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_we    (sram_we),
        .sram_wmask (sram_wmask),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_dout  (sram_dout)
    );

    always #5 clk = ~clk;

    // Macro model: synchronous read, byte-masked write, dout X after a write.
    always @(posedge clk) begin
        if (sram_we) begin
            for (int b = 0; b < 8; b++) begin
                if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
            end
            sram_dout <= 'x;
        end else begin
            sram_dout <= mem[sram_addr];
        end
    end

    function automatic logic [63:0] pat(input int i);
        logic [31:0] lo;
        lo = 32'h600D0000 + i;
        return {16'hA5A5, i[15:0], lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_wmask = 8'h00;
        req_addr  = 9'h000;
        req_wdata = 64'h0;
    endtask

    task automatic drive_req(input logic we, input logic [8:0] a,
                             input logic [63:0] d, input logic [7:0] m);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        req_wmask = m;
    endtask

    task automatic test_reset();
        rstb      = 1'b0;
        rsp_ready = 1'b1;
        drive_req(1'b1, 9'h0AA, 64'hDEAD_BEEF_0000_1111, 8'hFF);
        tick();
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid);
        end
        checks++;
        if (rsp_rdata !== 64'h0) begin
            failures++;
            $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata);
        end
        checks++;
        if (sram_we !== 1'b0 || sram_wmask !== 8'h00) begin
            failures++;
            $display("FAIL reset_sram_we got=%b/%h want=0/00", sram_we, sram_wmask);
        end
        drive_idle();
        rstb = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_req_ready got=%b want=1", req_ready);
        end
        tick();
    endtask

    // Eight reads issued every cycle; each response shows 2 edges after issue.
    task automatic test_back_to_back();
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k >= 2) begin
                checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== pat(k - 2)) begin
                    failures++;
                    $display("FAIL b2b_rsp%0d got=%b/%h want=1/%h", k - 2, rsp_valid, rsp_rdata, pat(k - 2));
                end
            end else begin
                checks++;
                if (rsp_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_early_valid%0d got=%b want=0", k, rsp_valid);
                end
            end
            if (k < 8) begin
                drive_req(1'b0, 9'(k), 64'h0, 8'h00);
                #1;
                checks++;
                if (req_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_ready%0d got=%b want=1", k, req_ready);
                end
            end else begin
                drive_idle();
            end
            tick();
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain got=%b want=0", rsp_valid);
        end
    endtask

    task automatic test_write_read();
        rsp_ready = 1'b1;
        drive_req(1'b1, 9'h005, 64'h0123456789ABCDEF, 8'hFF);
        #1;
        checks++;
        if (sram_we !== 1'b1 || sram_wmask !== 8'hFF || sram_addr !== 9'h005) begin
            failures++;
            $display("FAIL wr_drive got=%b/%h/%h want=1/ff/005", sram_we, sram_wmask, sram_addr);
        end
        tick();
        drive_req(1'b0, 9'h005, 64'h0, 8'hFF);
        #1;
        checks++;
        if (sram_we !== 1'b0 || sram_wmask !== 8'h00) begin
            failures++;
            $display("FAIL rd_drive got=%b/%h want=0/00", sram_we, sram_wmask);
        end
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_lat1 got=%b want=0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h0123456789ABCDEF) begin
            failures++;
            $display("FAIL wr_rd_data got=%b/%h want=1/0123456789abcdef", rsp_valid, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_pop got=%b want=0", rsp_valid);
        end
    endtask

    task automatic test_wmask();
        rsp_ready = 1'b1;
        drive_req(1'b1, 9'h1FF, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        tick();
        drive_req(1'b1, 9'h1FF, 64'h0, 8'h0F);
        tick();
        drive_req(1'b0, 9'h1FF, 64'h0, 8'h00);
        tick();
        drive_idle();
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hFFFF_FFFF_0000_0000) begin
            failures++;
            $display("FAIL wmask_data got=%b/%h want=1/ffffffff00000000", rsp_valid, rsp_rdata);
        end
        tick();
        // Idle with write-enable asserted but no valid: no macro write.
        req_we    = 1'b1;
        req_wmask = 8'hFF;
        #1;
        checks++;
        if (sram_we !== 1'b0 || sram_wmask !== 8'h00) begin
            failures++;
            $display("FAIL idle_no_write got=%b/%h want=0/00", sram_we, sram_wmask);
        end
        drive_idle();
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        drive_req(1'b0, 9'h010, 64'h0, 8'h00);
        tick();
        drive_req(1'b0, 9'h011, 64'h0, 8'h00);
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready2 got=%b want=1", req_ready);
        end
        tick();
        drive_req(1'b0, 9'h012, 64'h0, 8'h00);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full1 got=%b want=0", req_ready);
        end
        tick();
        tick();
        checks++;
        if (req_ready !== 1'b0 || sram_we !== 1'b0) begin
            failures++;
            $display("FAIL bp_full2 got=%b/%b want=0/0", req_ready, sram_we);
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== pat(16)) begin
            failures++;
            $display("FAIL bp_head_stable got=%b/%h want=1/%h", rsp_valid, rsp_rdata, pat(16));
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got=%b want=1", req_ready);
        end
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== pat(17)) begin
            failures++;
            $display("FAIL bp_rsp1 got=%b/%h want=1/%h", rsp_valid, rsp_rdata, pat(17));
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== pat(18)) begin
            failures++;
            $display("FAIL bp_rsp2 got=%b/%h want=1/%h", rsp_valid, rsp_rdata, pat(18));
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain got=%b want=0", rsp_valid);
        end
    endtask

    task automatic test_reset_inflight();
        rsp_ready = 1'b1;
        drive_req(1'b0, 9'h003, 64'h0, 8'h00);
        tick();
        drive_idle();
        rstb = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_inflight_valid got=%b want=0", rsp_valid);
        end
        tick();
        rstb = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_inflight_ready got=%b want=1", req_ready);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_inflight_norsp%0d got=%b want=0", k, rsp_valid);
            end
        end
    endtask

    task automatic test_interleave();
        rsp_ready = 1'b1;
        drive_req(1'b1, 9'h020, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF);
        tick();
        drive_req(1'b0, 9'h020, 64'h0, 8'h00);
        tick();
        drive_req(1'b1, 9'h020, 64'h5555_5555_5555_5555, 8'hFF);
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 64'hAAAA_AAAA_AAAA_AAAA) begin
            failures++;
            $display("FAIL ilv_rsp0 got=%b/%h want=1/aaaaaaaaaaaaaaaa", rsp_valid, rsp_rdata);
        end
        drive_req(1'b0, 9'h020, 64'h0, 8'h00);
        tick();
        drive_idle();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL ilv_gap got=%b want=0", rsp_valid);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 64'h5555_5555_5555_5555) begin
            failures++;
            $display("FAIL ilv_rsp1 got=%b/%h want=1/5555555555555555", rsp_valid, rsp_rdata);
        end
        tick();
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL ilv_drain got=%b want=0", rsp_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = pat(i);
        drive_idle();
        rsp_ready = 1'b1;
        test_reset();
        test_back_to_back();
        test_write_read();
        test_wmask();
        test_backpressure();
        test_reset_inflight();
        test_interleave();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
